// File: rtl/nochange_window_checker.sv
// Cycle-based $nochange checker: flags data events inside the window
// [ref rise - START_M, ref fall + END_M - 1] and reports them one cycle later.
module nochange_window_checker #(
    parameter int START_M      = 2,
    parameter int END_M        = 3,
    parameter bit DATA_POSEDGE = 1'b1,
    parameter int CNT_W        = 8,
    parameter int TS_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_sig,
    input  logic             data_sig,
    input  logic             cond,
    input  logic             clr,
    output logic             viol_pulse,
    output logic             notifier,
    output logic [CNT_W-1:0] viol_count,
    output logic [TS_W-1:0]  first_viol_time,
    output logic             first_valid
);

    localparam int HW = (START_M > 0) ? START_M : 1;
    // The fall cycle itself is the first tail cycle, so TAIL holds END_M-1 cycles.
    localparam logic [3:0] TAIL_LOAD = 4'((END_M > 1) ? (END_M - 1) : 0);

    typedef enum logic [1:0] {IDLE, HIGH, TAIL} state_t;

    state_t          state, state_n;
    logic            armed, armed_n;
    logic [3:0]      tail_cnt, tail_n;
    logic            ref_q, data_q;
    logic            rise, fall, ev;
    logic [HW-1:0]   hist, hist_next;
    logic            hist_any, shift_in;
    logic            viol, hist_clear;
    logic [TS_W-1:0] ts;

    assign rise     = ref_sig & ~ref_q;
    assign fall     = ~ref_sig & ref_q;
    assign ev       = DATA_POSEDGE ? (data_sig & ~data_q) : (data_sig ^ data_q);
    assign hist_any = (START_M > 0) ? |hist : 1'b0;
    // Events already reported must not be re-counted by a later rise.
    assign shift_in = ev & ~viol;

    generate
        if (HW == 1) begin : g_hist1
            assign hist_next = shift_in;
        end else begin : g_histn
            assign hist_next = {hist[HW-2:0], shift_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            tail_cnt <= '0;
            ref_q    <= 1'b0;
            data_q   <= 1'b0;
            hist     <= '0;
            ts       <= '0;
        end else begin
            state    <= state_n;
            armed    <= armed_n;
            tail_cnt <= tail_n;
            ref_q    <= ref_sig;
            data_q   <= data_sig;
            ts       <= ts + 1'b1;
            if (hist_clear || START_M == 0) begin
                hist <= '0;
            end else begin
                hist <= hist_next;
            end
        end
    end

    always_comb begin
        state_n = state;
        armed_n = armed;
        tail_n  = tail_cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    armed_n = cond;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (END_M > 1) begin
                        state_n = TAIL;
                        tail_n  = TAIL_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            TAIL: begin
                if (rise) begin
                    state_n = HIGH;
                    armed_n = cond;
                end else if (tail_cnt <= 4'd1) begin
                    state_n = IDLE;
                end else begin
                    tail_n = tail_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        viol       = 1'b0;
        hist_clear = clr;
        case (state)
            IDLE: begin
                if (rise && cond && (ev || hist_any)) begin
                    viol       = 1'b1;
                    hist_clear = 1'b1;
                end
            end
            HIGH: begin
                if (!fall || END_M > 0) begin
                    viol = armed & ev;
                end
            end
            TAIL: begin
                if (rise) begin
                    if (cond && (ev || hist_any)) begin
                        viol       = 1'b1;
                        hist_clear = 1'b1;
                    end
                end else begin
                    viol = armed & ev;
                end
            end
            default: viol = 1'b0;
        endcase
    end

    // A violation coinciding with clr is dropped entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_pulse      <= 1'b0;
            notifier        <= 1'b0;
            viol_count      <= '0;
            first_viol_time <= '0;
            first_valid     <= 1'b0;
        end else if (clr) begin
            viol_pulse      <= 1'b0;
            viol_count      <= '0;
            first_viol_time <= '0;
            first_valid     <= 1'b0;
        end else if (viol) begin
            viol_pulse <= 1'b1;
            notifier   <= ~notifier;
            if (viol_count != '1) begin
                viol_count <= viol_count + 1'b1;
            end
            if (!first_valid) begin
                first_viol_time <= ts;
                first_valid     <= 1'b1;
            end
        end else begin
            viol_pulse <= 1'b0;
        end
    end

endmodule
